shape_renderer: RTL and testbench
=================================

// Module: shape_renderer
// PURPOSE
//  Pixel-stream generator: renders an outline rectangle, isosceles triangle or circle as a write stream
//  (x, y, plot) into the framebuffer/classifier path. Sits between the UI/test controller and the
//  framebuffer writer. Emits the shape's first pixel again as its last pixel, so the stream forms a closed figure.
// PARAMETERS
//  SCREEN_W  320  visible width; x >= SCREEN_W is off-screen
//  SCREEN_H  240  visible height; y >= SCREEN_H is off-screen
// PORTS
//  clk         in   1  single clock, all logic on posedge
//  reset       in   1  synchronous, active-high
//  start       in   1  request render; accepted only in IDLE
//  shape_sel   in   2  0=rect, 1=triangle, 2=circle, 3=none
//  x0          in   9  bounding-box left; sampled at start
//  y0          in   8  bounding-box top; sampled at start
//  size        in   8  S: rect side / triangle height / circle radius; sampled at start
//  x           out  9  pixel x, valid while plot=1
//  y           out  8  pixel y, valid while plot=1
//  plot        out  1  pixel valid (drives classifier enable)
//  plot_ready  in   1  sink accepts pixel this cycle
//  busy        out  1  render in progress
//  done        out  1  one-cycle completion pulse
// BEHAVIOUR
//  - Reset value of every output is 0. Reset mid-render aborts the render: next cycle IDLE, plot=0, no done.
//  - FSM: IDLE -> DRAW -> CLOSE -> FIN -> IDLE. FIN drives done=1 and busy=0 for one cycle.
//  - Start is accepted in IDLE; start is ignored in every other state.
//  - shape_sel=3 or S=0: IDLE -> FIN. done is asserted the cycle after start, and no pixels are emitted.
//  - Registered outputs. The first plot appears the cycle after start. busy is high from that cycle until FIN.
//  - Handshake: a pixel transfers when plot && plot_ready.
//    - While plot && !plot_ready, x and y hold stable.
//    - Throughput is one pixel per cycle.
//  - Internal coordinate arithmetic is 11-bit signed, so x0+2S and cx-y cannot overflow.
//  - Rect: 4S pixels, in this order:
//      top    (x0..x0+S-1, y0)
//      right  (x0+S, y0..y0+S-1)
//      bottom (x0+S..x0+1, y0+S)
//      left   (x0, y0+S..y0+1)
//  - Triangle: apex (x0+S, y0); 4S pixels, in this order:
//      right edge (x0+S+i, y0+i), i=0..S-1
//      base       (x0+2S-j, y0+S), j=0..2S-1
//      left edge  (x0+k, y0+S-k), k=0..S-1
//  - Circle: centre cx=x0+S, cy=y0+S, r=S; midpoint algorithm.
//    - Start values: px=0, py=r, d=1-r.
//    - Loop while px<=py. Each step emits 8 points, in this order:
//      (cx+px,cy-py) (cx+py,cy-px) (cx+py,cy+px) (cx+px,cy+py) (cx-px,cy+py) (cx-py,cy+px) (cx-py,cy-px) (cx-px,cy-py)
//    - Duplicate points are emitted as-is.
//    - Update: if d<0 then d+=2px+3; else d+=2(px-py)+5 and py--. Then px++.
//  - CLOSE: re-emits the shape's first pixel once. Then FIN.
// CONFIGURATION
//  - SHAPE_RENDER_CLIP_EN defined:
//    - Pixels with x<0, x>=SCREEN_W, y<0 or y>=SCREEN_H are skipped, including the CLOSE pixel.
//    - A skipped pixel costs one cycle with plot=0.
//  - SHAPE_RENDER_CLIP_EN undefined:
//    - Every pixel is emitted, with coordinates truncated to 9/8 bits (wrap-around).
// STRUCTURE
//  - shape_pkg: shape codes (SHAPE_RECT/TRI/CIRC/NONE), FSM state encoding, SCREEN_W/H defaults, coordinate widths.
//  - Sub-module shape_circle_stepper:
//    - Holds the px/py/d registers and the 0..7 octant index.
//    - Advances on a step enable.
//    - Reports last when px>py after the update.
//  - Rect and triangle use an edge counter plus a per-edge index inside shape_renderer.
// TESTING
//  1. Rect x0=10, y0=20, S=5, plot_ready=1:
//     - 21 plots: first (10,20), 6th (15,20), 20th (10,21), 21st (10,20).
//     - done pulses the cycle after the 21st transfer.
//  2. Circle x0=50, y0=50, S=1:
//     - Plots in order: (51,50) (52,51) (52,51) (51,52) (51,52) (50,51) (50,51) (51,50), then close (51,50).
//  3. Triangle x0=0, y0=0, S=2 with plot_ready toggling every cycle:
//     - Transferred sequence: (2,0) (3,1) (4,2) (3,2) (2,2) (1,2) (0,2) (1,1), then close (2,0).
//     - x/y stable whenever ready=0.
//  4. Clip (SHAPE_RENDER_CLIP_EN), rect x0=318, y0=0, S=4:
//     - Exactly 8 plots: (318,0) (319,0) (319,4) (318,4) (318,3) (318,2) (318,1), then close (318,0).
//  5. Pulse start again mid-render; separately, assert reset mid-render:
//     - Second start is ignored and the original pixel count is unchanged.
//     - Reset gives plot=busy=done=0 the next cycle, and a new start renders normally.
//  6. shape_sel=3, or S=0 with shape_sel=0:
//     - Zero plots; done=1 exactly one cycle after start.

Source files
------------

// File: rtl/shape_pkg.sv
// ---------------------------------------------------------------------------
// shape_pkg
// Shared definitions for the shape renderer: shape codes, FSM state
// encoding, default screen size, coordinate widths and the on-screen test
// used when clipping is enabled (SHAPE_RENDER_CLIP_EN, see shape_renderer).
// ---------------------------------------------------------------------------
package shape_pkg;

    // Widths of the external coordinate ports and of the size input
    localparam int X_W     = 9;
    localparam int Y_W     = 8;
    localparam int SIZE_W  = 8;

    // Internal coordinates are 11-bit signed so x0+2S and cx-py never overflow
    localparam int COORD_W = 11;

    // Midpoint decision variable needs one extra bit over the coordinates
    localparam int D_W     = 12;

    // Default visible screen
    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;

    typedef logic signed [COORD_W-1:0] coord_t;
    typedef logic signed [D_W-1:0]     dvar_t;

    typedef enum logic [1:0] {
        SHAPE_RECT = 2'd0,
        SHAPE_TRI  = 2'd1,
        SHAPE_CIRC = 2'd2,
        SHAPE_NONE = 2'd3
    } shape_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAW  = 2'd1,
        ST_CLOSE = 2'd2,
        ST_FIN   = 2'd3
    } state_e;

    // True when a signed pixel coordinate lands inside a w x h screen
    function automatic logic onScreen(input coord_t px, input coord_t py,
                                      input int w, input int h);
        return (px >= coord_t'(0)) && (px < coord_t'(w)) &&
               (py >= coord_t'(0)) && (py < coord_t'(h));
    endfunction

endpackage

// File: rtl/shape_circle_stepper.sv
// ---------------------------------------------------------------------------
// shape_circle_stepper
// Midpoint-circle walker. Holds px/py/d and the octant index 0..7 of the
// point currently presented. Each step moves to the next octant; after
// octant 7 the midpoint update runs and the octant wraps to 0. The "next"
// outputs show where the walker will be after a step, so the renderer can
// register the following pixel in the same cycle it accepts the current one.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_load          restart the walk with radius i_radius
//   i_radius        circle radius (loaded on i_load)
//   i_step          advance by one point
//   o_nextPx/Py     px/py after the next step
//   o_nextOct       octant index after the next step
//   o_last          the current point is the final point of the circle
// ---------------------------------------------------------------------------
module shape_circle_stepper
    import shape_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [SIZE_W-1:0] i_radius,
    input  logic              i_step,
    output coord_t            o_nextPx,
    output coord_t            o_nextPy,
    output logic [2:0]        o_nextOct,
    output logic              o_last
);

    coord_t     r_px;
    coord_t     r_py;
    dvar_t      r_d;
    logic [2:0] r_oct;

    coord_t     w_updPx;
    coord_t     w_updPy;
    dvar_t      w_updD;
    dvar_t      w_pxD;
    dvar_t      w_pyD;

    // Midpoint update that applies once all eight octant points are out
    always_comb begin
        w_pxD   = {r_px[COORD_W-1], r_px};
        w_pyD   = {r_py[COORD_W-1], r_py};
        w_updPx = r_px + coord_t'(1);
        w_updPy = r_py;
        w_updD  = r_d + (w_pxD <<< 1) + dvar_t'(3);
        if (!r_d[D_W-1]) begin
            w_updD  = r_d + ((w_pxD - w_pyD) <<< 1) + dvar_t'(5);
            w_updPy = r_py - coord_t'(1);
        end
    end

    // Walk position after one step: next octant, or the updated px/py
    always_comb begin
        o_nextPx  = r_px;
        o_nextPy  = r_py;
        o_nextOct = r_oct + 3'd1;
        if (r_oct == 3'd7) begin
            o_nextPx  = w_updPx;
            o_nextPy  = w_updPy;
            o_nextOct = 3'd0;
        end
        o_last = (r_oct == 3'd7) && (w_updPx > w_updPy);
    end

    // Walker registers; a load always wins over a step
    always_ff @(posedge clk) begin
        if (reset) begin
            r_px  <= '0;
            r_py  <= '0;
            r_d   <= '0;
            r_oct <= '0;
        end else if (i_load) begin
            r_px  <= '0;
            r_py  <= coord_t'({3'b000, i_radius});
            r_d   <= dvar_t'(1) - dvar_t'({4'b0000, i_radius});
            r_oct <= '0;
        end else if (i_step) begin
            r_px  <= o_nextPx;
            r_py  <= o_nextPy;
            r_oct <= o_nextOct;
            if (r_oct == 3'd7) begin
                r_d <= w_updD;
            end
        end
    end

endmodule

// File: rtl/shape_renderer.sv
// ---------------------------------------------------------------------------
// shape_renderer
// Turns a shape request (outline rectangle, isosceles triangle or circle)
// into a stream of (x, y) pixel writes with a plot/plot_ready handshake.
// The first pixel of each shape is re-emitted at the end to close it.
// Build option: define SHAPE_RENDER_CLIP_EN to skip off-screen pixels
// (one idle cycle with plot=0 each); otherwise every pixel is emitted with
// coordinates truncated to 9/8 bits.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            render request, accepted only when idle
//   shape_sel        0 rect, 1 triangle, 2 circle, 3 none
//   x0, y0, size     bounding-box origin and S, sampled at start
//   x, y, plot       pixel output, valid while plot=1
//   plot_ready       sink accepts the pixel this cycle
//   busy             render in progress
//   done             one-cycle completion pulse
// ---------------------------------------------------------------------------
module shape_renderer
    import shape_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        shape_sel,
    input  logic [X_W-1:0]    x0,
    input  logic [Y_W-1:0]    y0,
    input  logic [SIZE_W-1:0] size,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic              plot,
    input  logic              plot_ready,
    output logic              busy,
    output logic              done
);

`ifdef SHAPE_RENDER_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    state_e     r_state;
    state_e     w_stateNext;

    shape_e     r_shape;
    coord_t     r_x0;
    coord_t     r_y0;
    coord_t     r_s;
    logic [1:0] r_edge;
    coord_t     r_idx;
    coord_t     r_curX;
    coord_t     r_curY;
    coord_t     r_firstX;
    coord_t     r_firstY;
    logic       r_plotOk;

    logic       w_accept;
    logic       w_advance;
    logic       w_drawLast;
    logic       w_busy;
    logic       w_done;
    logic       w_plot;
    logic       w_step;

    coord_t     w_inX0;
    coord_t     w_inY0;
    coord_t     w_inS;
    coord_t     w_startX;
    coord_t     w_startY;

    coord_t     w_edgeLen;
    logic       w_edgeEnd;
    logic       w_lastEdge;
    logic [1:0] w_nEdge;
    coord_t     w_nIdx;
    coord_t     w_nextX;
    coord_t     w_nextY;
    coord_t     w_cx;
    coord_t     w_cy;

    coord_t     w_cirPx;
    coord_t     w_cirPy;
    logic [2:0] w_cirOct;
    logic       w_cirLast;

    shape_circle_stepper u_stepper (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_accept),
        .i_radius  (size),
        .i_step    (w_step),
        .o_nextPx  (w_cirPx),
        .o_nextPy  (w_cirPy),
        .o_nextOct (w_cirOct),
        .o_last    (w_cirLast)
    );

    // First pixel straight from the request: rect starts at its corner,
    // triangle (apex) and circle (top point) both start at (x0+S, y0)
    always_comb begin
        w_inX0   = coord_t'({2'b00, x0});
        w_inY0   = coord_t'({3'b000, y0});
        w_inS    = coord_t'({3'b000, size});
        w_startX = (shape_sel == SHAPE_RECT) ? w_inX0 : (w_inX0 + w_inS);
        w_startY = w_inY0;
    end

    // A presented pixel moves on when it transfers, or at once when it was
    // clipped away (r_plotOk low)
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && start;
        w_advance = ((r_state == ST_DRAW) || (r_state == ST_CLOSE)) &&
                    (!r_plotOk || plot_ready);
        w_step    = w_advance && (r_state == ST_DRAW) && (r_shape == SHAPE_CIRC);
    end

    // Edge walk for rect/triangle: the triangle base is 2S long, every
    // other edge is S long
    always_comb begin
        w_edgeLen  = ((r_shape == SHAPE_TRI) && (r_edge == 2'd1)) ? (r_s <<< 1) : r_s;
        w_edgeEnd  = (r_idx == (w_edgeLen - coord_t'(1)));
        w_lastEdge = (r_shape == SHAPE_TRI) ? (r_edge == 2'd2) : (r_edge == 2'd3);
        w_nEdge    = w_edgeEnd ? (r_edge + 2'd1) : r_edge;
        w_nIdx     = w_edgeEnd ? coord_t'(0) : (r_idx + coord_t'(1));
        w_drawLast = (r_shape == SHAPE_CIRC) ? w_cirLast : (w_edgeEnd && w_lastEdge);
    end

    // Pixel that follows the one currently presented
    always_comb begin
        w_cx    = r_x0 + r_s;
        w_cy    = r_y0 + r_s;
        w_nextX = r_x0;
        w_nextY = r_y0;
        case (r_shape)
            SHAPE_RECT: begin
                case (w_nEdge)
                    2'd0:    begin w_nextX = r_x0 + w_nIdx;       w_nextY = r_y0;               end
                    2'd1:    begin w_nextX = r_x0 + r_s;          w_nextY = r_y0 + w_nIdx;      end
                    2'd2:    begin w_nextX = r_x0 + r_s - w_nIdx; w_nextY = r_y0 + r_s;         end
                    default: begin w_nextX = r_x0;                w_nextY = r_y0 + r_s - w_nIdx; end
                endcase
            end
            SHAPE_TRI: begin
                case (w_nEdge)
                    2'd0:    begin w_nextX = r_x0 + r_s + w_nIdx;          w_nextY = r_y0 + w_nIdx;       end
                    2'd1:    begin w_nextX = r_x0 + (r_s <<< 1) - w_nIdx;  w_nextY = r_y0 + r_s;          end
                    default: begin w_nextX = r_x0 + w_nIdx;                w_nextY = r_y0 + r_s - w_nIdx; end
                endcase
            end
            SHAPE_CIRC: begin
                case (w_cirOct)
                    3'd0:    begin w_nextX = w_cx + w_cirPx; w_nextY = w_cy - w_cirPy; end
                    3'd1:    begin w_nextX = w_cx + w_cirPy; w_nextY = w_cy - w_cirPx; end
                    3'd2:    begin w_nextX = w_cx + w_cirPy; w_nextY = w_cy + w_cirPx; end
                    3'd3:    begin w_nextX = w_cx + w_cirPx; w_nextY = w_cy + w_cirPy; end
                    3'd4:    begin w_nextX = w_cx - w_cirPx; w_nextY = w_cy + w_cirPy; end
                    3'd5:    begin w_nextX = w_cx - w_cirPy; w_nextY = w_cy + w_cirPx; end
                    3'd6:    begin w_nextX = w_cx - w_cirPy; w_nextY = w_cy - w_cirPx; end
                    default: begin w_nextX = w_cx - w_cirPx; w_nextY = w_cy - w_cirPy; end
                endcase
            end
            default: begin
                w_nextX = r_x0;
                w_nextY = r_y0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // FSM next state and status decode; an empty request goes straight to FIN
    always_comb begin
        w_stateNext = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_plot      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if ((shape_sel == SHAPE_NONE) || (size == '0)) begin
                        w_stateNext = ST_FIN;
                    end else begin
                        w_stateNext = ST_DRAW;
                    end
                end
            end
            ST_DRAW: begin
                w_busy = 1'b1;
                w_plot = r_plotOk;
                if (w_advance && w_drawLast) begin
                    w_stateNext = ST_CLOSE;
                end
            end
            ST_CLOSE: begin
                w_busy = 1'b1;
                w_plot = r_plotOk;
                if (w_advance) begin
                    w_stateNext = ST_FIN;
                end
            end
            ST_FIN: begin
                w_done      = 1'b1;
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Pixel datapath: load the request and its first pixel on accept, then
    // register the following pixel each time the current one moves on; the
    // last drawn pixel is followed by a copy of the first to close the shape
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shape  <= SHAPE_RECT;
            r_x0     <= '0;
            r_y0     <= '0;
            r_s      <= '0;
            r_edge   <= '0;
            r_idx    <= '0;
            r_curX   <= '0;
            r_curY   <= '0;
            r_firstX <= '0;
            r_firstY <= '0;
            r_plotOk <= 1'b0;
        end else if (w_accept) begin
            r_shape  <= shape_e'(shape_sel);
            r_x0     <= w_inX0;
            r_y0     <= w_inY0;
            r_s      <= w_inS;
            r_edge   <= '0;
            r_idx    <= '0;
            r_curX   <= w_startX;
            r_curY   <= w_startY;
            r_firstX <= w_startX;
            r_firstY <= w_startY;
            r_plotOk <= !CLIP_EN || onScreen(w_startX, w_startY, SCREEN_W, SCREEN_H);
        end else if (w_advance && (r_state == ST_DRAW)) begin
            if (w_drawLast) begin
                r_curX   <= r_firstX;
                r_curY   <= r_firstY;
                r_plotOk <= !CLIP_EN || onScreen(r_firstX, r_firstY, SCREEN_W, SCREEN_H);
            end else begin
                r_edge   <= w_nEdge;
                r_idx    <= w_nIdx;
                r_curX   <= w_nextX;
                r_curY   <= w_nextY;
                r_plotOk <= !CLIP_EN || onScreen(w_nextX, w_nextY, SCREEN_W, SCREEN_H);
            end
        end
    end

    assign x    = r_curX[X_W-1:0];
    assign y    = r_curY[Y_W-1:0];
    assign plot = w_plot;
    assign busy = w_busy;
    assign done = w_done;

endmodule

// File: tb/tb_shape_renderer.sv
// ---------------------------------------------------------------------------
// tb_shape_renderer
// Self-checking bench for shape_renderer. A reference model builds the
// expected pixel list straight from the shape rules (plain loops), applies
// clipping or 9/8-bit wrap depending on SHAPE_RENDER_CLIP_EN, and each test
// compares the transferred pixel stream and done/busy timing against it.
// ---------------------------------------------------------------------------
module tb_shape_renderer;

`ifdef SHAPE_RENDER_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   localparam int BUDGET = 4000;

   logic       clk;
   logic       reset;
   logic       start;
   logic [1:0] shape_sel;
   logic [8:0] x0;
   logic [7:0] y0;
   logic [7:0] size;
   logic [8:0] x;
   logic [7:0] y;
   logic       plot;
   logic       plot_ready;
   logic       busy;
   logic       done;

   int compared;
   int mismatched;

   int expX[$];
   int expY[$];
   int gotX[$];
   int gotY[$];
   int doneCycle;
   int doneCount;
   int lastXfer;
   int stableErr;
   int busyErr;
   int timedOut;

   shape_renderer dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .shape_sel  (shape_sel),
      .x0         (x0),
      .y0         (y0),
      .size       (size),
      .x          (x),
      .y          (y),
      .plot       (plot),
      .plot_ready (plot_ready),
      .busy       (busy),
      .done       (done)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: raw pixel list from the shape rules, close pixel
   // appended, then clipped or wrapped
   task automatic buildModel(input int shp, input int ax, input int ay, input int s);
      int rx[$];
      int ry[$];
      int px;
      int py;
      int d;
      int cx;
      int cy;
      expX.delete();
      expY.delete();
      if (shp == 3 || s == 0) return;
      if (shp == 0) begin
         for (int i = 0; i < s; i++) begin rx.push_back(ax + i);     ry.push_back(ay);         end
         for (int i = 0; i < s; i++) begin rx.push_back(ax + s);     ry.push_back(ay + i);     end
         for (int i = 0; i < s; i++) begin rx.push_back(ax + s - i); ry.push_back(ay + s);     end
         for (int i = 0; i < s; i++) begin rx.push_back(ax);         ry.push_back(ay + s - i); end
      end else if (shp == 1) begin
         for (int i = 0; i < s; i++)     begin rx.push_back(ax + s + i);     ry.push_back(ay + i);     end
         for (int j = 0; j < 2 * s; j++) begin rx.push_back(ax + 2 * s - j); ry.push_back(ay + s);     end
         for (int k = 0; k < s; k++)     begin rx.push_back(ax + k);         ry.push_back(ay + s - k); end
      end else begin
         cx = ax + s;
         cy = ay + s;
         px = 0;
         py = s;
         d  = 1 - s;
         while (px <= py) begin
            rx.push_back(cx + px); ry.push_back(cy - py);
            rx.push_back(cx + py); ry.push_back(cy - px);
            rx.push_back(cx + py); ry.push_back(cy + px);
            rx.push_back(cx + px); ry.push_back(cy + py);
            rx.push_back(cx - px); ry.push_back(cy + py);
            rx.push_back(cx - py); ry.push_back(cy + px);
            rx.push_back(cx - py); ry.push_back(cy - px);
            rx.push_back(cx - px); ry.push_back(cy - py);
            if (d < 0) begin
               d = d + 2 * px + 3;
            end else begin
               d  = d + 2 * (px - py) + 5;
               py = py - 1;
            end
            px = px + 1;
         end
      end
      rx.push_back(rx[0]);
      ry.push_back(ry[0]);
      foreach (rx[i]) begin
         if (CLIP) begin
            if (rx[i] >= 0 && rx[i] < 320 && ry[i] >= 0 && ry[i] < 240) begin
               expX.push_back(rx[i]);
               expY.push_back(ry[i]);
            end
         end else begin
            expX.push_back(rx[i] & 511);
            expY.push_back(ry[i] & 255);
         end
      end
   endtask

   // Drive one request and record the transfers, done timing, busy level
   // and hold-stability; readyMode 0 = always ready, 1 = toggling starting
   // low, 2 = random. pulseAt > 0 pulses a second start with other inputs.
   task automatic applyStimulus(input int shp, input int ax, input int ay, input int s,
                                input int readyMode, input int pulseAt);
      logic       prevHold;
      logic [8:0] prevX;
      logic [7:0] prevY;
      gotX.delete();
      gotY.delete();
      doneCycle = -1;
      doneCount = 0;
      lastXfer  = -1;
      stableErr = 0;
      busyErr   = 0;
      timedOut  = 1;
      prevHold  = 1'b0;
      prevX     = '0;
      prevY     = '0;
      @(negedge clk);
      start      = 1'b1;
      shape_sel  = shp[1:0];
      x0         = ax[8:0];
      y0         = ay[7:0];
      size       = s[7:0];
      plot_ready = 1'b1;
      for (int c = 1; c <= BUDGET; c++) begin
         @(negedge clk);
         start = (c == pulseAt);
         if (c == pulseAt) begin
            shape_sel = 2'd1;
            x0        = 9'd7;
            y0        = 8'd9;
            size      = 8'd20;
         end
         case (readyMode)
            0:       plot_ready = 1'b1;
            1:       plot_ready = (c % 2 == 0);
            default: plot_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (prevHold && (plot !== 1'b1 || x !== prevX || y !== prevY)) stableErr++;
         if (done === 1'b1) begin
            doneCount++;
            if (doneCycle < 0) doneCycle = c;
         end
         if (busy !== ((doneCycle < 0) ? 1'b1 : 1'b0) && !(doneCycle < 0 && c == 1 && done === 1'b1)) busyErr++;
         if (plot === 1'b1 && plot_ready === 1'b1) begin
            gotX.push_back(int'(x));
            gotY.push_back(int'(y));
            lastXfer = c;
         end
         prevHold = (plot === 1'b1) && (plot_ready === 1'b0);
         prevX    = x;
         prevY    = y;
         if (doneCycle > 0 && c >= doneCycle + 2) begin
            timedOut = 0;
            break;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      start      = 1'b0;
      shape_sel  = 2'd0;
      x0         = '0;
      y0         = '0;
      size       = '0;
      plot_ready = 1'b0;
      repeat (3) @(negedge clk);
      compared++;
      if ({plot, busy, done, x, y} !== 20'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_outputs got plot=%b busy=%b done=%b x=%0d y=%0d want all 0",
                  plot, busy, done, x, y);
      end
      reset = 1'b0;
      @(negedge clk);
      compared++;
      if ({plot, busy, done} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL reset_idle got plot=%b busy=%b done=%b want 000", plot, busy, done);
      end
   endtask

   task automatic test_rect();
      buildModel(0, 10, 20, 5);
      applyStimulus(0, 10, 20, 5, 0, 0);
      compared++;
      if (gotX.size() != 21 || expX.size() != 21) begin
         mismatched++;
         $display("[TB] FAIL rect_count got %0d want 21", gotX.size());
      end else begin
         compared++;
         if (gotX[0] != 10 || gotY[0] != 20 || gotX[5] != 15 || gotY[5] != 20 ||
             gotX[19] != 10 || gotY[19] != 21 || gotX[20] != 10 || gotY[20] != 20) begin
            mismatched++;
            $display("[TB] FAIL rect_spots got (%0d,%0d) (%0d,%0d) (%0d,%0d) (%0d,%0d) want (10,20) (15,20) (10,21) (10,20)",
                     gotX[0], gotY[0], gotX[5], gotY[5], gotX[19], gotY[19], gotX[20], gotY[20]);
         end
         foreach (expX[i]) begin
            compared++;
            if (gotX[i] != expX[i] || gotY[i] != expY[i]) begin
               mismatched++;
               $display("[TB] FAIL rect_pixel[%0d] got (%0d,%0d) want (%0d,%0d)", i, gotX[i], gotY[i], expX[i], expY[i]);
            end
         end
      end
      compared++;
      if (timedOut != 0 || doneCount != 1 || doneCycle != lastXfer + 1 || busyErr != 0) begin
         mismatched++;
         $display("[TB] FAIL rect_done got doneCycle=%0d count=%0d busyErr=%0d timeout=%0d want doneCycle=%0d count=1",
                  doneCycle, doneCount, busyErr, timedOut, lastXfer + 1);
      end
   endtask

   task automatic test_circle();
      int wantX[9];
      int wantY[9];
      wantX = '{51, 52, 52, 51, 51, 50, 50, 51, 51};
      wantY = '{50, 51, 51, 52, 52, 51, 51, 50, 50};
      buildModel(2, 50, 50, 1);
      applyStimulus(2, 50, 50, 1, 0, 0);
      compared++;
      if (gotX.size() != 9) begin
         mismatched++;
         $display("[TB] FAIL circle_count got %0d want 9", gotX.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            compared++;
            if (gotX[i] != wantX[i] || gotY[i] != wantY[i] || expX[i] != wantX[i]) begin
               mismatched++;
               $display("[TB] FAIL circle_pixel[%0d] got (%0d,%0d) want (%0d,%0d)", i, gotX[i], gotY[i], wantX[i], wantY[i]);
            end
         end
      end
      compared++;
      if (timedOut != 0 || doneCount != 1 || doneCycle != lastXfer + 1) begin
         mismatched++;
         $display("[TB] FAIL circle_done got doneCycle=%0d count=%0d want doneCycle=%0d count=1", doneCycle, doneCount, lastXfer + 1);
      end
   endtask

   task automatic test_triangle_toggle();
      int wantX[9];
      int wantY[9];
      wantX = '{2, 3, 4, 3, 2, 1, 0, 1, 2};
      wantY = '{0, 1, 2, 2, 2, 2, 2, 1, 0};
      applyStimulus(1, 0, 0, 2, 1, 0);
      compared++;
      if (gotX.size() != 9) begin
         mismatched++;
         $display("[TB] FAIL tri_count got %0d want 9", gotX.size());
      end else begin
         for (int i = 0; i < 9; i++) begin
            compared++;
            if (gotX[i] != wantX[i] || gotY[i] != wantY[i]) begin
               mismatched++;
               $display("[TB] FAIL tri_pixel[%0d] got (%0d,%0d) want (%0d,%0d)", i, gotX[i], gotY[i], wantX[i], wantY[i]);
            end
         end
      end
      compared++;
      if (stableErr != 0 || timedOut != 0 || doneCycle != lastXfer + 1) begin
         mismatched++;
         $display("[TB] FAIL tri_hold got stableErr=%0d doneCycle=%0d timeout=%0d want 0, %0d, 0",
                  stableErr, doneCycle, timedOut, lastXfer + 1);
      end
   endtask

   task automatic test_clip_edge();
      buildModel(0, 318, 0, 4);
      applyStimulus(0, 318, 0, 4, 0, 0);
      compared++;
      if (gotX.size() != (CLIP ? 8 : 17) || gotX.size() != expX.size()) begin
         mismatched++;
         $display("[TB] FAIL clip_count got %0d want %0d", gotX.size(), expX.size());
      end else begin
         foreach (expX[i]) begin
            compared++;
            if (gotX[i] != expX[i] || gotY[i] != expY[i]) begin
               mismatched++;
               $display("[TB] FAIL clip_pixel[%0d] got (%0d,%0d) want (%0d,%0d)", i, gotX[i], gotY[i], expX[i], expY[i]);
            end
         end
      end
      compared++;
      if (timedOut != 0 || doneCount != 1) begin
         mismatched++;
         $display("[TB] FAIL clip_done got count=%0d timeout=%0d want 1, 0", doneCount, timedOut);
      end
   endtask

   task automatic test_restart_ignored();
      buildModel(0, 30, 40, 6);
      applyStimulus(0, 30, 40, 6, 0, 5);
      compared++;
      if (gotX.size() != expX.size() || doneCount != 1 || timedOut != 0) begin
         mismatched++;
         $display("[TB] FAIL restart_count got %0d pixels %0d done want %0d pixels 1 done",
                  gotX.size(), doneCount, expX.size());
      end else begin
         foreach (expX[i]) begin
            compared++;
            if (gotX[i] != expX[i] || gotY[i] != expY[i]) begin
               mismatched++;
               $display("[TB] FAIL restart_pixel[%0d] got (%0d,%0d) want (%0d,%0d)", i, gotX[i], gotY[i], expX[i], expY[i]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      @(negedge clk);
      start      = 1'b1;
      shape_sel  = 2'd0;
      x0         = 9'd100;
      y0         = 8'd100;
      size       = 8'd10;
      plot_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      compared++;
      if ({plot, busy, done} !== 3'b000) begin
         mismatched++;
         $display("[TB] FAIL reset_mid got plot=%b busy=%b done=%b want 000", plot, busy, done);
      end
      reset = 1'b0;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
      end
      compared++;
      if (bad != 0) begin
         mismatched++;
         $display("[TB] FAIL reset_quiet got %0d active cycles want 0", bad);
      end
      buildModel(2, 80, 60, 7);
      applyStimulus(2, 80, 60, 7, 0, 0);
      compared++;
      if (gotX.size() != expX.size() || doneCount != 1 || timedOut != 0) begin
         mismatched++;
         $display("[TB] FAIL reset_rerun got %0d pixels want %0d", gotX.size(), expX.size());
      end else begin
         foreach (expX[i]) begin
            compared++;
            if (gotX[i] != expX[i] || gotY[i] != expY[i]) begin
               mismatched++;
               $display("[TB] FAIL reset_rerun[%0d] got (%0d,%0d) want (%0d,%0d)", i, gotX[i], gotY[i], expX[i], expY[i]);
            end
         end
      end
   endtask

   task automatic test_empty();
      applyStimulus(3, 10, 10, 5, 0, 0);
      compared++;
      if (gotX.size() != 0 || doneCycle != 1 || doneCount != 1 || busyErr != 0) begin
         mismatched++;
         $display("[TB] FAIL empty_none got %0d pixels doneCycle=%0d count=%0d busyErr=%0d want 0, 1, 1, 0",
                  gotX.size(), doneCycle, doneCount, busyErr);
      end
      applyStimulus(0, 10, 10, 0, 0, 0);
      compared++;
      if (gotX.size() != 0 || doneCycle != 1 || doneCount != 1 || busyErr != 0) begin
         mismatched++;
         $display("[TB] FAIL empty_size0 got %0d pixels doneCycle=%0d count=%0d busyErr=%0d want 0, 1, 1, 0",
                  gotX.size(), doneCycle, doneCount, busyErr);
      end
   endtask

   task automatic test_random();
      int shp;
      int ax;
      int ay;
      int s;
      for (int n = 0; n < 24; n++) begin
         shp = $urandom_range(0, 2);
         ax  = $urandom_range(0, 511);
         ay  = $urandom_range(0, 255);
         s   = $urandom_range(1, 40);
         buildModel(shp, ax, ay, s);
         applyStimulus(shp, ax, ay, s, 2, 0);
         compared++;
         if (gotX.size() != expX.size() || stableErr != 0 || doneCount != 1 ||
             timedOut != 0 || busyErr != 0 || doneCycle != ((lastXfer < 0) ? doneCycle : lastXfer + 1)) begin
            mismatched++;
            $display("[TB] FAIL random[%0d] shape=%0d x0=%0d y0=%0d S=%0d got %0d pixels stable=%0d done=%0d busyErr=%0d want %0d pixels",
                     n, shp, ax, ay, s, gotX.size(), stableErr, doneCount, busyErr, expX.size());
         end else begin
            foreach (expX[i]) begin
               compared++;
               if (gotX[i] != expX[i] || gotY[i] != expY[i]) begin
                  mismatched++;
                  $display("[TB] FAIL random[%0d] pixel[%0d] got (%0d,%0d) want (%0d,%0d)",
                           n, i, gotX[i], gotY[i], expX[i], expY[i]);
               end
            end
         end
      end
   endtask

   // Test sequence and summary
   initial begin
      compared   = 0;
      mismatched = 0;
      test_reset();
      test_rect();
      test_circle();
      test_triangle_toggle();
      test_clip_edge();
      test_restart_ignored();
      test_reset_mid();
      test_empty();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
